barrel_shift_arbiter: RTL and testbench
=======================================

BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin between requesters and 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_data  input  16  requester 0 operand.
REQ-007 req0_amt  input  4  requester 0 shift control value.
REQ-008 req1_valid, req1_ready, req1_data, req1_amt  as REQ-004..007, for requester 1.
REQ-009 res_valid  output  1  res_data/res_id hold a valid result.
REQ-010 res_ready  input  1  consumer accepts the result when high with res_valid.
REQ-011 res_data  output  16  registered shifter output.
REQ-012 res_id  output  1  index of the requester that issued the result.
REQ-013 busy  output  1  high whenever res_valid is high or any reqX_valid is high.

Function
REQ-014 One shared barrel_shift_16bit instance shall serve both requesters; its in/ctrl inputs are the granted requester's data/amt.
REQ-015 FSM states: IDLE (no result held) and FULL (result held).
REQ-016 Accept condition: a request is accepted when it is granted and (state==IDLE or res_ready==1).
REQ-017 Only the granted requester's ready shall be high; ready may depend combinationally on reqX_valid and res_ready.
REQ-018 Grant with one valid: that requester.
REQ-019 Grant with both valid, FIXED_PRIO=0: the requester not equal to last_id.
REQ-020 Grant with both valid, FIXED_PRIO=1: requester 0.
REQ-021 last_id shall update to the accepted requester's index on every accept.
REQ-022 On accept: res_data <= shifter output, res_id <= granted index, state -> FULL.
REQ-023 Latency: result is visible exactly 1 cycle after accept.
REQ-024 FULL with res_ready=1 and no accept: state -> IDLE, res_valid falls next cycle.
REQ-025 FULL with res_ready=1 and an accept in the same cycle: state stays FULL and the new result replaces the old one, giving throughput of 1 result per cycle.
REQ-026 FULL with res_ready=0: res_data and res_id shall hold stable, both readies shall be 0 and no accept occurs.
REQ-027 res_valid = (state==FULL).
REQ-028 Results shall be delivered in accept order; no result shall be dropped or duplicated.

Reset
REQ-029 On rst assertion, immediately and asynchronously: state=IDLE, res_valid=0, res_data=16'h0000, res_id=0, last_id=1, so that requester 0 wins the first tie.
REQ-030 While rst is high, req0_ready and req1_ready shall be 0.
REQ-031 Reset during FULL shall discard the held result without requiring a res_ready handshake.

Structure
REQ-032 A shared package shall hold the state encoding (IDLE=0, FULL=1), the DATA_W=16 and AMT_W=4 constants, and the requester-index width.
REQ-033 barrel_shift_16bit shall be the sole sub-module, instantiated unmodified.
REQ-034 Grant logic, the operand mux and the FSM shall live in this module; no second shifter instance is permitted.

Verification
REQ-035 Scenario: reset, then req0 data=0x4001 amt=0 with res_ready=1 -> one cycle later res_valid=1, res_data=0x4001, res_id=0.
REQ-036 Scenario: both valid for 4 cycles, FIXED_PRIO=0, res_ready=1 -> res_id sequence 0,1,0,1 on consecutive cycles.
REQ-037 Scenario: req1 sweeps amt 0..15 with data=0x4001 and res_ready=1 -> 16 back-to-back results, each equal to the barrel_shift_16bit model output for that amt, all with res_id=1.
REQ-038 Scenario: result held with res_ready=0 for 5 cycles while both requesters are valid -> res_data stable, both readies 0; on the cycle res_ready rises, exactly one new request is accepted.
REQ-039 Scenario: rst pulse mid-cycle while FULL -> res_valid drops before the next edge; after release, a tie is granted to requester 0.
REQ-040 Scenario: FIXED_PRIO=1 with both valid for 6 cycles -> all 6 results carry res_id=0 and req1_ready stays 0.

Source files
------------

// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester shift arbiter.
package barrel_shift_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;
  localparam int ID_W   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/barrel_shift_arbiter_shifter.sv
// 16-bit rotate-left barrel shifter; ctrl gives the rotate distance.
module barrel_shift_16bit (
  input  logic [15:0] in,
  input  logic [3:0]  ctrl,
  output logic [15:0] out
);
  logic [4:0][15:0] stage;

  assign stage[0] = in;

  // One log stage per control bit, rotating by 2**s when that bit is set.
  for (genvar s = 0; s < 4; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stage[s+1] = ctrl[s] ? {stage[s][15-SH:0], stage[s][15:16-SH]} : stage[s];
  end

  assign out = stage[4];
endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two requesters share one barrel shifter; a one-entry result register feeds the consumer.
module barrel_shift_arbiter
  import barrel_shift_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ID_W-1:0]   res_id,
  output logic              busy
);
  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_id, gnt_id;
  logic              gnt_any, accept;
  logic [DATA_W-1:0] sh_in, sh_out;
  logic [AMT_W-1:0]  sh_amt;

  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = FIXED_PRIO ? '0 : ~last_id;
    else                          gnt_id = req1_valid ? ID_W'(1) : '0;
  end

  // A held result blocks new work unless the consumer drains it this cycle.
  assign accept     = gnt_any && !rst && (state == IDLE || res_ready);
  assign req0_ready = accept && (gnt_id == '0);
  assign req1_ready = accept && (gnt_id == ID_W'(1));

  assign sh_in  = (gnt_id == ID_W'(1)) ? req1_data : req0_data;
  assign sh_amt = (gnt_id == ID_W'(1)) ? req1_amt  : req0_amt;

  barrel_shift_16bit u_shift (
    .in   (sh_in),
    .ctrl (sh_amt),
    .out  (sh_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FULL;
      FULL:    if (!accept && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // last_id resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_id   <= '0;
      last_id  <= ID_W'(1);
    end else if (accept) begin
      res_data <= sh_out;
      res_id   <= gnt_id;
      last_id  <= gnt_id;
    end
  end

  assign res_valid = (state == FULL);
  assign busy      = res_valid | req0_valid | req1_valid;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus, checked against a result-slot model.
module tb_barrel_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, res_ready = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic [3:0]  a0 = '0, a1 = '0;

  logic [1:0]  r0_rdy, r1_rdy, rv, rid, bsy;
  logic [15:0] rd [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0_rdy[0]), .req0_data(d0), .req0_amt(a0),
    .req1_valid(v1), .req1_ready(r1_rdy[0]), .req1_data(d1), .req1_amt(a1),
    .res_valid(rv[0]), .res_ready(res_ready), .res_data(rd[0]), .res_id(rid[0]),
    .busy(bsy[0])
  );

  barrel_shift_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0_rdy[1]), .req0_data(d0), .req0_amt(a0),
    .req1_valid(v1), .req1_ready(r1_rdy[1]), .req1_data(d1), .req1_amt(a1),
    .res_valid(rv[1]), .res_ready(res_ready), .res_data(rd[1]), .res_id(rid[1]),
    .busy(bsy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid [2];
  logic [15:0] m_data  [2];
  logic        m_id    [2];
  logic        m_last  [2];

  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] w;
    w = {16'h0, x} << n;
    return w[15:0] | w[31:16];
  endfunction

  // Returns {req1_ready, req0_ready} that the rules demand right now.
  function automatic logic [1:0] exp_rdy(input int d);
    logic g;
    if (rst) return 2'b00;
    if (m_valid[d] && !res_ready) return 2'b00;
    if (v0 && v1)  g = (d == 1) ? 1'b0 : ~m_last[d];
    else if (v0)   g = 1'b0;
    else if (v1)   g = 1'b1;
    else return 2'b00;
    return g ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] <= 1'b0; m_data[d] <= '0; m_id[d] <= 1'b0; m_last[d] <= 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [1:0] r;
        r = exp_rdy(d);
        if (r != 2'b00) begin
          m_valid[d] <= 1'b1;
          m_id[d]    <= r[1];
          m_last[d]  <= r[1];
          m_data[d]  <= r[1] ? rotl(d1, a1) : rotl(d0, a0);
        end else if (res_ready) begin
          m_valid[d] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0] er;
      er = exp_rdy(d);
      chk($sformatf("model_ready%0d", d), {30'h0, r1_rdy[d], r0_rdy[d]}, {30'h0, er});
      chk($sformatf("model_valid%0d", d), {31'h0, rv[d]}, {31'h0, m_valid[d]});
      chk($sformatf("model_busy%0d", d), {31'h0, bsy[d]}, {31'h0, m_valid[d] | v0 | v1});
      if (m_valid[d]) begin
        chk($sformatf("model_data%0d", d), {16'h0, rd[d]}, {16'h0, m_data[d]});
        chk($sformatf("model_id%0d", d), {31'h0, rid[d]}, {31'h0, m_id[d]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; res_ready = 0;
    rst = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", {31'h0, rv[d]}, 32'h0);
      chk("rst_data", {16'h0, rd[d]}, 32'h0);
      chk("rst_id", {31'h0, rid[d]}, 32'h0);
      chk("rst_rdy", {30'h0, r1_rdy[d], r0_rdy[d]}, 32'h0);
    end
    tick();
    rst = 0;
  endtask

  logic [15:0] sweep_tbl [16];
  logic [15:0] held;

  initial begin
    sweep_tbl = '{16'h4001, 16'h8002, 16'h0005, 16'h000A, 16'h0014, 16'h0028, 16'h0050, 16'h00A0,
                  16'h0140, 16'h0280, 16'h0500, 16'h0A00, 16'h1400, 16'h2800, 16'h5000, 16'hA000};
    #1;
    do_reset();

    // Single request, identity shift, one-cycle latency.
    v0 = 1; d0 = 16'h4001; a0 = 4'd0; res_ready = 1;
    @(negedge clk);
    chk("first_req0_ready", {31'h0, r0_rdy[0]}, 32'h1);
    tick();
    v0 = 0;
    chk("first_valid", {31'h0, rv[0]}, 32'h1);
    chk("first_data", {16'h0, rd[0]}, 32'h4001);
    chk("first_id", {31'h0, rid[0]}, 32'h0);
    tick();
    chk("drain_valid", {31'h0, rv[0]}, 32'h0);

    // Tie for 6 cycles: round-robin alternates, fixed priority always picks 0.
    do_reset();
    v0 = 1; v1 = 1; d0 = 16'h00F1; a0 = 4'd4; d1 = 16'h8001; a1 = 4'd1; res_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fixed_req1_ready", {31'h0, r1_rdy[1]}, 32'h0);
      tick();
      chk("rr_id", {31'h0, rid[0]}, {31'h0, i[0]});
      chk("rr_data", {16'h0, rd[0]}, i[0] ? 32'h0003 : 32'h0F10);
      chk("fixed_id", {31'h0, rid[1]}, 32'h0);
    end
    v0 = 0; v1 = 0;
    tick();

    // req1 alone sweeps every rotate distance back to back.
    v1 = 1; d1 = 16'h4001;
    for (int k = 0; k < 16; k++) begin
      a1 = k[3:0];
      tick();
      chk("sweep_data", {16'h0, rd[0]}, {16'h0, sweep_tbl[k]});
      chk("sweep_id", {31'h0, rid[0]}, 32'h1);
      chk("sweep_valid", {31'h0, rv[0]}, 32'h1);
    end
    v1 = 0;
    tick();

    // Backpressure: hold a result for 5 cycles with both requesters pending.
    res_ready = 0; v0 = 1; d0 = 16'h1234; a0 = 4'd8;
    tick();
    held = rd[0];
    chk("hold_capture", {16'h0, held}, 32'h3412);
    v1 = 1; d1 = 16'h0001; a1 = 4'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rdy", {30'h0, r1_rdy[0], r0_rdy[0]}, 32'h0);
      chk("hold_data", {16'h0, rd[0]}, {16'h0, held});
      tick();
    end
    res_ready = 1;
    @(negedge clk);
    chk("release_one", {31'h0, r0_rdy[0] ^ r1_rdy[0]}, 32'h1);
    chk("release_rr_pick", {31'h0, r1_rdy[0]}, 32'h1);
    tick();
    v0 = 0; v1 = 0;
    chk("release_data", {16'h0, rd[0]}, 32'h8000);
    tick();
    chk("release_drain", {31'h0, rv[0]}, 32'h0);

    // Asynchronous reset while a result is held.
    res_ready = 0; v0 = 1; d0 = 16'hBEEF; a0 = 4'd0;
    tick();
    v0 = 0;
    chk("pre_rst_full", {31'h0, rv[0]}, 32'h1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid0", {31'h0, rv[0]}, 32'h0);
    chk("async_rst_valid1", {31'h0, rv[1]}, 32'h0);
    tick();
    rst = 0; v0 = 1; v1 = 1; res_ready = 1; d0 = 16'h0102; d1 = 16'h0304;
    @(negedge clk);
    chk("post_rst_tie", {30'h0, r1_rdy[0], r0_rdy[0]}, 32'h1);
    tick();
    v0 = 0; v1 = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
